uart_rx_os: RTL and testbench

- Second-generation UART receiver: 16x-style oversampling, majority-vote bit sampling, false-start rejection.
- Runtime frame config: 5–8 data bits, optional parity, 1 or 2 stop bits; parity, framing and break detection.
- Received frames plus error flags are buffered in an internal FIFO drained over a valid/ready interface.
- Sits between the pad-side rx_serial line and the APB register block, replacing the single-byte receiver.

---
 rtl/uart_pkg.sv | 51 +++++
 rtl/uart_rx_fifo.sv | 55 +++++
 rtl/uart_rx_os.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the oversampling UART receiver: FSM states, frame config, FIFO entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    STOP2,
    WAIT_IDLE
  } state_e;

  // data_bits encoding
  localparam logic [1:0] DB_5 = 2'd0;
  localparam logic [1:0] DB_6 = 2'd1;
  localparam logic [1:0] DB_7 = 2'd2;
  localparam logic [1:0] DB_8 = 2'd3;

  // FIFO entry = {break, frame_err, parity_err, data[7:0]}
  localparam int ENTRY_W  = 11;
  localparam int DATA_LSB = 0;
  localparam int PERR_BIT = 8;
  localparam int FERR_BIT = 9;
  localparam int BRK_BIT  = 10;

  // Frame configuration captured at the start edge
  typedef struct packed {
    logic [1:0] data_bits;
    logic       parity_en;
    logic       parity_odd;
    logic       stop2;
  } cfg_t;

  function automatic logic [3:0] nbits(input logic [1:0] db);
    case (db)
      DB_5:    return 4'd5;
      DB_6:    return 4'd6;
      DB_7:    return 4'd7;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic brk, input logic ferr,
                                                    input logic perr, input logic [7:0] data);
    return {brk, ferr, perr, data};
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO holding received frames; head word is presented combinationally.
// Latency: a push is visible at the head one clk later.
// Backpressure: push is ignored when full unless a pop happens in the same cycle; pop when empty is ignored.
module uart_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // Head is forced to zero when empty so outputs never show stale storage
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];
  assign level_o = cnt_q;

  // Storage array, no reset needed since reads are gated by empty
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// UART receiver: oversampled 2-of-3 majority bit sampling, parity/framing/break checks, RX FIFO.
// Latency: FIFO write 1 clk after the final stop-bit decision; m_valid rises 1 clk after that.
// Backpressure: m_valid/m_ready pops the head; a frame arriving at a full FIFO with no pop is dropped and sets overflow.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          rx_en,
  input  logic [DIV_W-1:0]              os_div,
  input  logic [1:0]                    data_bits,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          stop2,
  input  logic                          rx_serial,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [7:0]                    m_data,
  output logic                          m_parity_err,
  output logic                          m_frame_err,
  output logic                          m_break,
  output logic                          rx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          overflow_clr
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE/2);
  localparam logic [TW-1:0] T_S2   = TW'(OVERSAMPLE/2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

  logic [1:0]         sync_q;
  logic               rx_prev_q;
  logic               rx_s, fall;
  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d, div_lim;
  logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
  logic [1:0]         samp_q, samp_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shreg_q, shreg_d, data_al;
  cfg_t               cfg_q, cfg_d;
  logic               par_bit_q, par_bit_d, par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic               wr_q, wr_d;
  logic [ENTRY_W-1:0] wr_dat_q, wr_dat_d, head;
  logic               overflow_q, overflow_d;
  logic               os_tick, bit_done, maj, fifo_full, fifo_empty;

  assign rx_s     = sync_q[1];
  assign fall     = rx_prev_q && !rx_s;
  assign div_lim  = (os_div == '0) ? DIV_W'(1) : os_div;
  assign os_tick  = (div_cnt_q >= div_lim - 1'b1);
  assign bit_done = os_tick && (tick_cnt_q == T_S2);
  // Third sample is taken live on the deciding tick
  assign maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  // Data was shifted in from the top, so right-align it for short frames
  assign data_al  = shreg_q >> (DB_8 - cfg_q.data_bits);

  // Next-state logic: tick timing, bit sampling, frame FSM, overflow flag
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    tick_cnt_d = tick_cnt_q;
    samp_d     = samp_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    cfg_d      = cfg_q;
    par_bit_d  = par_bit_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    wr_d       = 1'b0;
    wr_dat_d   = wr_dat_q;
    overflow_d = (overflow_q && !overflow_clr) || (wr_q && fifo_full && !m_ready);

    if (os_tick) begin
      div_cnt_d  = '0;
      tick_cnt_d = (tick_cnt_q == T_LAST) ? '0 : tick_cnt_q + 1'b1;
      if (tick_cnt_q == T_S0) samp_d[0] = rx_s;
      if (tick_cnt_q == T_S1) samp_d[1] = rx_s;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        div_cnt_d  = '0;
        tick_cnt_d = '0;
        if (rx_en && fall) begin
          cfg_d.data_bits  = data_bits;
          cfg_d.parity_en  = parity_en;
          cfg_d.parity_odd = parity_odd;
          cfg_d.stop2      = stop2;
          shreg_d   = '0;
          bit_cnt_d = '0;
          par_bit_d = 1'b0;
          par_err_d = 1'b0;
          frm_err_d = 1'b0;
          state_d   = START;
        end
      end
      START: if (bit_done) state_d = maj ? IDLE : DATA;
      DATA: begin
        if (bit_done) begin
          shreg_d   = {maj, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'(nbits(cfg_q.data_bits) - 4'd1))
            state_d = cfg_q.parity_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_done) begin
          par_bit_d = maj;
          par_err_d = ((^shreg_q) ^ maj) != cfg_q.parity_odd;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (!maj && shreg_q == '0 && !par_bit_q) begin
            // Break: restart bit timing so the idle qualification sees a full bit of high line
            wr_d       = 1'b1;
            wr_dat_d   = pack_entry(1'b1, 1'b1, 1'b0, 8'h00);
            div_cnt_d  = '0;
            tick_cnt_d = '0;
            state_d    = WAIT_IDLE;
          end else if (cfg_q.stop2) begin
            frm_err_d = !maj;
            state_d   = STOP2;
          end else begin
            wr_d     = 1'b1;
            wr_dat_d = pack_entry(1'b0, !maj, par_err_q, data_al);
            state_d  = IDLE;
          end
        end
      end
      STOP2: begin
        if (bit_done) begin
          wr_d     = 1'b1;
          wr_dat_d = pack_entry(1'b0, frm_err_q || !maj, par_err_q, data_al);
          state_d  = IDLE;
        end
      end
      WAIT_IDLE: begin
        if (!rx_s) begin
          div_cnt_d  = '0;
          tick_cnt_d = '0;
        end else if (os_tick && tick_cnt_q == T_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!rx_en && state_q != IDLE) begin
      state_d = IDLE;
      wr_d    = 1'b0;
    end
  end

  // State and datapath registers; synchroniser idles high
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
      samp_q     <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      cfg_q      <= '0;
      par_bit_q  <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      wr_q       <= 1'b0;
      wr_dat_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx_serial};
      rx_prev_q  <= rx_s;
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      samp_q     <= samp_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      cfg_q      <= cfg_d;
      par_bit_q  <= par_bit_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      wr_q       <= wr_d;
      wr_dat_q   <= wr_dat_d;
      overflow_q <= overflow_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .arst_i  (arst),
    .push_i  (wr_q),
    .data_i  (wr_dat_q),
    .pop_i   (m_ready),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign m_valid      = !fifo_empty;
  assign m_data       = head[DATA_LSB +: 8];
  assign m_parity_err = head[PERR_BIT];
  assign m_frame_err  = head[FERR_BIT];
  assign m_break      = head[BRK_BIT];
  assign rx_busy      = (state_q != IDLE);
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: table vectors, randomized frames against a frame-level model, hand corner sequences.
// Latency: n/a.
// Backpressure: consumer pops one entry at a time via m_ready pulses.
module tb_uart_rx_os;
  localparam int OS      = 16;
  localparam int DEPTH   = 8;
  localparam int DIV     = 4;
  localparam int BIT_CLK = OS * DIV;
  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;

  logic        clk = 1'b0;
  logic        arst, rx_en, parity_en, parity_odd, stop2, rx_serial, m_ready, overflow_clr;
  logic [15:0] os_div;
  logic [1:0]  data_bits;
  logic        m_valid, m_parity_err, m_frame_err, m_break, rx_busy, overflow;
  logic [7:0]  m_data;
  logic [3:0]  fifo_level;

  int tests  = 0;
  int failed = 0;
  int lat;

  always #5 clk = ~clk;

  uart_rx_os #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
    .clk(clk), .arst(arst), .rx_en(rx_en), .os_div(os_div), .data_bits(data_bits),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2), .rx_serial(rx_serial),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_parity_err(m_parity_err),
    .m_frame_err(m_frame_err), .m_break(m_break), .rx_busy(rx_busy), .fifo_level(fifo_level),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  typedef struct {
    logic [7:0] d;
    logic [1:0] db;
    logic       pe, po, s2, pflip, st1, st2;
    logic [7:0] ed;
    logic       epe, efe, ebrk;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  // Waits (bounded) for a head entry, compares every field, then pops it
  task automatic check_head(input string name, input logic [7:0] d, input logic pe,
                            input logic fe, input logic brk);
    int n = 0;
    while (!m_valid && n < 4 * BIT_CLK) begin
      @(negedge clk);
      n++;
    end
    check({name, " valid"}, m_valid, 1);
    check({name, " data"}, m_data, d);
    check({name, " parity_err"}, m_parity_err, pe);
    check({name, " frame_err"}, m_frame_err, fe);
    check({name, " break"}, m_break, brk);
    if (m_valid) pop();
  endtask

  // Drives one serial frame; optional one-tick noise pulse and rx_en drop at a given bit index
  task automatic send_frame(input logic [7:0] d, input logic [1:0] db, input logic pe,
                            input logic po, input logic s2, input logic pflip, input logic st1,
                            input logic st2, input int noise_bit, input int drop_bit);
    logic q[$];
    logic par;
    int   nb;
    nb  = 5 + int'(db);
    par = 1'b0;
    data_bits  = db;
    parity_en  = pe;
    parity_odd = po;
    stop2      = s2;
    q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      q.push_back(d[i]);
      par ^= d[i];
    end
    if (pe) q.push_back(par ^ po ^ pflip);
    q.push_back(st1);
    if (s2) q.push_back(st2);
    for (int b = 0; b < q.size(); b++) begin
      for (int c = 0; c < BIT_CLK; c++) begin
        @(negedge clk);
        if (b == drop_bit && c == 0) rx_en = 1'b0;
        rx_serial = q[b] ^ ((b == noise_bit && c >= 32 && c < 36) ? 1'b1 : 1'b0);
      end
    end
    @(negedge clk);
    rx_serial = 1'b1;
  endtask

  // Frame-level reference: what a receiver must report for a frame with these line values
  function automatic logic [10:0] model(input logic [7:0] d, input logic [1:0] db, input logic pe,
                                        input logic po, input logic s2, input logic pflip,
                                        input logic st1, input logic st2);
    int         nb;
    logic [7:0] m;
    logic       pbit;
    nb   = 5 + int'(db);
    m    = d & 8'((1 << nb) - 1);
    pbit = (^m) ^ po ^ pflip;
    if (m == 8'h00 && (!pe || !pbit) && !st1) return {1'b1, 1'b1, 1'b0, 8'h00};
    return {1'b0, (!st1 || (s2 && !st2)), (pe && (((^m) ^ pbit) != po)), m};
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[10];
    logic [10:0] exp_e;
    int          flen;

    tbl[0] = '{8'hA5, 2'd3, N, N, N, N, Y, Y, 8'hA5, N, N, N};
    tbl[1] = '{8'h35, 2'd2, Y, N, N, Y, Y, Y, 8'h35, Y, N, N};
    tbl[2] = '{8'h35, 2'd2, Y, N, N, N, Y, Y, 8'h35, N, N, N};
    tbl[3] = '{8'hC3, 2'd3, N, N, Y, N, Y, N, 8'hC3, N, Y, N};
    tbl[4] = '{8'h5A, 2'd3, N, N, N, N, N, Y, 8'h5A, N, Y, N};
    tbl[5] = '{8'h1F, 2'd0, Y, Y, N, N, Y, Y, 8'h1F, N, N, N};
    tbl[6] = '{8'hFF, 2'd1, Y, N, Y, N, Y, Y, 8'h3F, N, N, N};
    tbl[7] = '{8'h00, 2'd3, Y, Y, N, N, Y, Y, 8'h00, N, N, N};
    tbl[8] = '{8'h00, 2'd3, N, N, N, N, N, Y, 8'h00, N, Y, Y};
    tbl[9] = '{8'h7F, 2'd2, Y, Y, Y, Y, Y, Y, 8'h7F, Y, N, N};

    arst = 1'b1; rx_en = 1'b1; os_div = 16'(DIV); data_bits = 2'd3; parity_en = 1'b0;
    parity_odd = 1'b0; stop2 = 1'b0; rx_serial = 1'b1; m_ready = 1'b0; overflow_clr = 1'b0;
    cycles(5);
    check("reset m_valid", m_valid, 0);
    check("reset m_data", m_data, 0);
    check("reset m_parity_err", m_parity_err, 0);
    check("reset m_frame_err", m_frame_err, 0);
    check("reset m_break", m_break, 0);
    check("reset rx_busy", rx_busy, 0);
    check("reset fifo_level", fifo_level, 0);
    check("reset overflow", overflow, 0);
    arst = 1'b0;
    cycles(4);

    // Table vectors, with start-edge-to-m_valid latency window per frame
    for (int i = 0; i < 10; i++) begin
      flen = 2 + 5 + int'(tbl[i].db) + int'(tbl[i].pe) + int'(tbl[i].s2 && !tbl[i].ebrk);
      fork
        send_frame(tbl[i].d, tbl[i].db, tbl[i].pe, tbl[i].po, tbl[i].s2, tbl[i].pflip,
                   tbl[i].st1, tbl[i].st2, -1, -1);
        begin
          lat = 0;
          while (!m_valid && lat < 20 * BIT_CLK) begin
            @(negedge clk);
            lat++;
          end
        end
      join
      tests++;
      if (lat < (flen - 1) * BIT_CLK || lat > flen * BIT_CLK) begin
        failed++;
        $display("FAIL vec%0d latency: got %0d clks, expected %0d..%0d", i, lat,
                 (flen - 1) * BIT_CLK, flen * BIT_CLK);
      end
      cycles(2 * BIT_CLK);
      check_head($sformatf("vec%0d", i), tbl[i].ed, tbl[i].epe, tbl[i].efe, tbl[i].ebrk);
    end

    // Randomized frames against the reference model
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      logic [1:0] db;
      logic       pe, po, s2, pf, st1, st2;
      d   = 8'($urandom);
      db  = 2'($urandom_range(0, 3));
      pe  = 1'($urandom_range(0, 1));
      po  = 1'($urandom_range(0, 1));
      s2  = 1'($urandom_range(0, 1));
      pf  = ($urandom_range(0, 3) == 0);
      st1 = ($urandom_range(0, 4) != 0);
      st2 = ($urandom_range(0, 4) != 0);
      exp_e = model(d, db, pe, po, s2, pf, st1, st2);
      send_frame(d, db, pe, po, s2, pf, st1, st2, -1, -1);
      cycles(2 * BIT_CLK);
      check_head($sformatf("rand%0d", i), exp_e[7:0], exp_e[8], exp_e[9], exp_e[10]);
    end

    // Majority vote masks a one-tick noise pulse inside data bit 2
    send_frame(8'h96, 2'd3, N, N, N, N, Y, Y, 3, -1);
    cycles(BIT_CLK);
    check_head("noise", 8'h96, N, N, N);

    // Glitches: start is detected, then rejected at the start-bit vote
    rx_serial = 1'b0; cycles(2); rx_serial = 1'b1;
    cycles(4);
    check("glitch busy", rx_busy, 1);
    cycles(2 * BIT_CLK);
    check("glitch idle", rx_busy, 0);
    check("glitch no entry", fifo_level, 0);
    rx_serial = 1'b0; cycles(6 * DIV); rx_serial = 1'b1;
    cycles(2 * BIT_CLK);
    check("short pulse idle", rx_busy, 0);
    check("short pulse no entry", fifo_level, 0);

    // Break: single entry, receiver waits for a full bit of idle line
    data_bits = 2'd3; parity_en = 1'b0; stop2 = 1'b0;
    rx_serial = 1'b0;
    cycles(20 * BIT_CLK);
    check("break level", fifo_level, 1);
    check("break still busy", rx_busy, 1);
    check_head("break", 8'h00, N, Y, Y);
    rx_serial = 1'b1;
    cycles(BIT_CLK / 2);
    check("break wait idle", rx_busy, 1);
    cycles(2 * BIT_CLK);
    check("break back idle", rx_busy, 0);
    check("break no extra", fifo_level, 0);
    send_frame(8'h3C, 2'd3, N, N, N, N, Y, Y, -1, -1);
    cycles(BIT_CLK);
    check_head("after break", 8'h3C, N, N, N);

    // rx_en dropped mid-frame: abort, no entry
    send_frame(8'h55, 2'd3, N, N, N, N, Y, Y, -1, 4);
    check("rx_en drop busy", rx_busy, 0);
    check("rx_en drop no entry", fifo_level, 0);
    rx_en = 1'b1;
    cycles(BIT_CLK);

    // Overflow: nine frames into an eight-entry FIFO with no consumer
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 2'd3, N, N, N, N, Y, Y, -1, -1);
      cycles(BIT_CLK);
    end
    check("ovf level", fifo_level, DEPTH);
    check("ovf flag", overflow, 1);
    check("ovf head", m_data, 8'h01);
    for (int i = 1; i <= 8; i++) check_head($sformatf("drain%0d", i), 8'(i), N, N, N);
    check("drain empty", fifo_level, 0);
    check("drain m_valid", m_valid, 0);
    check("ovf sticky", overflow, 1);
    pop();
    check("pop empty level", fifo_level, 0);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    check("ovf cleared", overflow, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
